// File: rtl/dlatch_seq_if.sv
// Bus between the dlatch_seq sequencer and whatever drives it. The sequencer
// uses the slave view; the controller and the external latch use the master view.
interface dlatch_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] word;
    logic             flush;
    logic             latch_d;
    logic             latch_en;
    logic             latch_q;
    logic             latch_qb;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] readback;
    logic [3:0]       state;

    modport slave (
        input  start, word, flush, latch_q, latch_qb,
        output latch_d, latch_en, busy, done, err, readback, state
    );

    modport master (
        output start, word, flush, latch_q, latch_qb,
        input  latch_d, latch_en, busy, done, err, readback, state
    );
endinterface

// File: rtl/dlatch_seq.sv
// Drives a word into an external D latch one bit at a time, LSB first.
// Each bit goes through setup (en low), enable (en high), hold (en low) and
// a one-cycle readback check of the latch outputs.
// A flush aborts everything and forces the latch to 0.
module dlatch_seq #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic        clk,
    input  logic        rst,
    dlatch_seq_if.slave bus
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0000,
        ST_SETUP  = 4'b0001,
        ST_ENABLE = 4'b0010,
        ST_HOLD   = 4'b0011,
        ST_CHECK  = 4'b0100,
        ST_END    = 4'b0111,
        ST_FLUSH  = 4'b1000
    } state_t;

    state_t           state_q,    state_d;
    logic [31:0]      cnt_q,      cnt_d;
    logic [IDXW-1:0]  idx_q,      idx_d;
    logic [WIDTH-1:0] word_q,     word_d;
    logic [WIDTH-1:0] readback_q, readback_d;
    logic             err_q,      err_d;
    logic             latch_d_q,  latch_d_d;
    logic             latch_en_q, latch_en_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    // Next-state logic. The output registers are loaded with the values that
    // belong to the state being entered, so latch_d/latch_en/busy line up with
    // the state register. done is the exception: it is raised on the edge that
    // leaves END, which places it one cycle after END itself.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        word_d     = word_q;
        readback_d = readback_q;
        err_d      = err_q;
        done_d     = 1'b0;

        if (bus.flush && (state_q != ST_FLUSH)) begin
            state_d = ST_FLUSH;
            cnt_d   = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        word_d     = bus.word;
                        err_d      = 1'b0;
                        readback_d = '0;
                        idx_d      = '0;
                        cnt_d      = 32'd0;
                        state_d    = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == 32'(SETUP_CYC - 1)) begin
                        cnt_d   = 32'd0;
                        state_d = ST_ENABLE;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                ST_ENABLE: begin
                    if (cnt_q == 32'(EN_CYC - 1)) begin
                        cnt_d   = 32'd0;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 32'(HOLD_CYC - 1)) begin
                        cnt_d   = 32'd0;
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                ST_CHECK: begin
                    readback_d[idx_q] = bus.latch_q;
                    if ((bus.latch_q != word_q[idx_q]) || (bus.latch_qb != ~bus.latch_q)) begin
                        err_d = 1'b1;
                    end
                    if (idx_q == IDXW'(WIDTH - 1)) begin
                        state_d = ST_END;
                    end else begin
                        idx_d   = idx_q + IDXW'(1);
                        state_d = ST_SETUP;
                    end
                end
                ST_END: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_FLUSH: begin
                    if (cnt_q == 32'(EN_CYC - 1)) begin
                        cnt_d   = 32'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 32'd0;
                end
            endcase
        end

        latch_en_d = (state_d == ST_ENABLE) || (state_d == ST_FLUSH);
        busy_d     = (state_d != ST_IDLE);
        case (state_d)
            ST_SETUP, ST_ENABLE, ST_HOLD, ST_CHECK: latch_d_d = word_d[idx_d];
            default:                                latch_d_d = 1'b0;
        endcase
    end

    // State and output registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 32'd0;
            idx_q      <= '0;
            word_q     <= '0;
            readback_q <= '0;
            err_q      <= 1'b0;
            latch_d_q  <= 1'b0;
            latch_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            readback_q <= readback_d;
            err_q      <= err_d;
            latch_d_q  <= latch_d_d;
            latch_en_q <= latch_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.latch_d  = latch_d_q;
    assign bus.latch_en = latch_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.readback = readback_q;

endmodule

// File: tb/tb_dlatch_seq.sv
// Testbench for dlatch_seq: an ideal transparent D latch model with
// selectable faults, directed scenarios plus randomized words.
module tb_dlatch_seq;

    localparam int WIDTH     = 8;
    localparam int SETUP_CYC = 1;
    localparam int EN_CYC    = 2;
    localparam int HOLD_CYC  = 1;
    localparam int BIT_CYC   = SETUP_CYC + EN_CYC + HOLD_CYC + 1;
    localparam int OP_EDGES  = WIDTH * BIT_CYC + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dlatch_seq_if #(.WIDTH(WIDTH)) bus();

    dlatch_seq #(
        .WIDTH(WIDTH),
        .SETUP_CYC(SETUP_CYC),
        .EN_CYC(EN_CYC),
        .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int faultMode = 0;
    int enCycles  = 0;
    int enRises   = 0;
    int doneCount = 0;
    logic prevEn  = 1'b0;
    logic lq      = 1'b0;

    // Ideal D latch: transparent while enable is high.
    always @(bus.latch_en or bus.latch_d) begin
        if (bus.latch_en) lq = bus.latch_d;
    end

    // Fault 1 sticks Q at 0; fault 2 shorts QB to Q while bit 3 is in flight.
    assign bus.latch_q  = (faultMode == 1) ? 1'b0 : lq;
    assign bus.latch_qb = (faultMode == 2 && enRises == 4) ? bus.latch_q : ~bus.latch_q;

    // Activity monitor on the falling edge, away from the DUT update edge.
    always @(negedge clk) begin
        if (bus.latch_en) enCycles++;
        if (bus.latch_en && !prevEn) enRises++;
        prevEn = bus.latch_en;
        if (bus.done) doneCount++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [WIDTH-1:0] refReadback(logic [WIDTH-1:0] w, int mode);
        return (mode == 1) ? '0 : w;
    endfunction

    function automatic logic refErr(logic [WIDTH-1:0] w, int mode);
        if (mode == 1) return (w != '0);
        if (mode == 2) return 1'b1;
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic stepEdges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a word with start for one edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] w);
        bus.start = 1'b1;
        bus.word  = w;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        enCycles  = 0;
        enRises   = 0;
        doneCount = 0;
    endtask

    task automatic waitDone(output int edges);
        edges = 0;
        while (edges < 200 && bus.done !== 1'b1) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    initial begin
        int edges;
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] mask;
        int bitsDone;

        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.word  = '0;

        // Reset state
        stepEdges(3);
        checkOutput("rst_state", 32'(bus.state), 32'h0);
        checkOutput("rst_busy", 32'(bus.busy), 32'h0);
        checkOutput("rst_done", 32'(bus.done), 32'h0);
        checkOutput("rst_err", 32'(bus.err), 32'h0);
        checkOutput("rst_readback", 32'(bus.readback), 32'h0);
        checkOutput("rst_latch_d", 32'(bus.latch_d), 32'h0);
        checkOutput("rst_latch_en", 32'(bus.latch_en), 32'h0);
        rst = 1'b0;
        stepEdges(1);

        // Nominal word with ideal latch
        applyStimulus(8'hA5);
        waitDone(edges);
        checkOutput("a5_done_edge", 32'(edges), 32'(OP_EDGES));
        checkOutput("a5_readback", 32'(bus.readback), 32'h0A5);
        checkOutput("a5_err", 32'(bus.err), 32'h0);
        checkOutput("a5_en_cycles", 32'(enCycles), 32'(WIDTH * EN_CYC));
        checkOutput("a5_en_pulses", 32'(enRises), 32'(WIDTH));
        checkOutput("a5_idle_at_done", 32'(bus.state), 32'h0);
        checkOutput("a5_busy_at_done", 32'(bus.busy), 32'h0);
        stepEdges(1);
        checkOutput("a5_done_pulse", 32'(bus.done), 32'h0);

        // Random words with ideal latch
        for (int i = 0; i < 4; i++) begin
            w = WIDTH'($urandom);
            applyStimulus(w);
            waitDone(edges);
            checkOutput("rand_done_edge", 32'(edges), 32'(OP_EDGES));
            checkOutput("rand_readback", 32'(bus.readback), 32'(refReadback(w, 0)));
            checkOutput("rand_err", 32'(bus.err), 32'(refErr(w, 0)));
            stepEdges(1);
        end

        // Q stuck at 0 with all-ones word
        faultMode = 1;
        applyStimulus(8'hFF);
        stepEdges(BIT_CYC - 1);
        checkOutput("stuck_err_before_check", 32'(bus.err), 32'h0);
        stepEdges(1);
        checkOutput("stuck_err_after_check", 32'(bus.err), 32'h1);
        waitDone(edges);
        checkOutput("stuck_done_edge", 32'(edges + BIT_CYC), 32'(OP_EDGES));
        checkOutput("stuck_readback", 32'(bus.readback), 32'(refReadback(8'hFF, 1)));
        checkOutput("stuck_err_final", 32'(bus.err), 32'(refErr(8'hFF, 1)));
        faultMode = 0;
        stepEdges(1);

        // QB shorted to Q on bit 3
        faultMode = 2;
        w = WIDTH'($urandom);
        applyStimulus(w);
        waitDone(edges);
        checkOutput("qb_done_edge", 32'(edges), 32'(OP_EDGES));
        checkOutput("qb_err", 32'(bus.err), 32'(refErr(w, 2)));
        checkOutput("qb_readback", 32'(bus.readback), 32'(refReadback(w, 2)));
        faultMode = 0;
        stepEdges(1);

        // Second start while busy is ignored
        applyStimulus(8'hA5);
        stepEdges(4);
        bus.start = 1'b1;
        bus.word  = 8'h00;
        stepEdges(1);
        bus.start = 1'b0;
        waitDone(edges);
        checkOutput("restart_done_edge", 32'(edges + 5), 32'(OP_EDGES));
        checkOutput("restart_readback", 32'(bus.readback), 32'h0A5);
        checkOutput("restart_err", 32'(bus.err), 32'h0);
        stepEdges(1);

        // Flush at cycle 10, held into FLUSH to show it does not restart
        applyStimulus(8'hA5);
        stepEdges(9);
        bus.flush = 1'b1;
        stepEdges(1);
        checkOutput("flush_state", 32'(bus.state), 32'h8);
        checkOutput("flush_en1", 32'(bus.latch_en), 32'h1);
        checkOutput("flush_d1", 32'(bus.latch_d), 32'h0);
        checkOutput("flush_busy", 32'(bus.busy), 32'h1);
        stepEdges(1);
        bus.flush = 1'b0;
        checkOutput("flush_en2", 32'(bus.latch_en), 32'h1);
        checkOutput("flush_d2", 32'(bus.latch_d), 32'h0);
        stepEdges(1);
        checkOutput("flush_to_idle", 32'(bus.state), 32'h0);
        checkOutput("flush_busy_low", 32'(bus.busy), 32'h0);
        checkOutput("flush_en_low", 32'(bus.latch_en), 32'h0);
        bitsDone = (10 - 1) / BIT_CYC;
        mask = WIDTH'((1 << bitsDone) - 1);
        checkOutput("flush_readback_kept", 32'(bus.readback), 32'(8'hA5 & mask));
        stepEdges(40);
        checkOutput("flush_no_done", 32'(doneCount), 32'h0);

        // Flush beats start in IDLE
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.word  = 8'hFF;
        stepEdges(1);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        checkOutput("flush_idle_state", 32'(bus.state), 32'h8);
        stepEdges(EN_CYC);
        checkOutput("flush_idle_back", 32'(bus.state), 32'h0);
        checkOutput("flush_idle_readback", 32'(bus.readback), 32'(8'hA5 & mask));

        // Reset at cycle 20 of an operation
        applyStimulus(8'hA5);
        stepEdges(19);
        rst = 1'b1;
        stepEdges(1);
        checkOutput("midrst_outputs",
                    32'({bus.state, bus.busy, bus.done, bus.err, bus.latch_d, bus.latch_en, bus.readback}),
                    32'h0);
        rst = 1'b0;
        stepEdges(50);
        checkOutput("midrst_no_done", 32'(doneCount), 32'h0);
        checkOutput("midrst_idle", 32'(bus.busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
